// File: rtl/fir_transposed_param.sv
// Reconfigurable transposed-form FIR filter with double-buffered coefficients.
//
// Coefficients are written into a shadow bank through a single-port RAM-style
// interface while the filter keeps running on the active bank. Once the load
// window closes, the next sample strobe copies shadow -> active, latches the
// new tap count and clears the partial-sum chain, all in one edge.
//
// Ports:
//   iClk_12M          single clock
//   iRsn              asynchronous active-low reset
//   iEnSample_300k    one-cycle sample strobe
//   iCoeffiUpdateFlag coefficient load window (high = open)
//   iCsnRam           chip select, active low
//   iWrnRam           0 = write, 1 = read
//   iAddrRam          coefficient index, valid range 1..TAPS
//   iWrDtRam          coefficient write data (signed)
//   iNumOfCoeff       requested tap count, latched at swap (clamped to TAPS)
//   iFirIn            input sample (signed)
//   oRdDtRam          shadow-bank readback, 1 clk latency
//   oFirOut           filter output (signed, saturated), 1 clk after strobe
//   oFirValid         one-cycle pulse when oFirOut updates
//   oSwapPend         high while a bank swap is pending
module fir_transposed_param #(
  parameter int TAPS = 33,
  parameter int CW   = 16,
  parameter int DW   = 3,
  parameter int OW   = 16,
  parameter int ACCW = 24,
  parameter int AW   = 6
) (
  input  logic                 iClk_12M,
  input  logic                 iRsn,
  input  logic                 iEnSample_300k,
  input  logic                 iCoeffiUpdateFlag,
  input  logic                 iCsnRam,
  input  logic                 iWrnRam,
  input  logic [AW-1:0]        iAddrRam,
  input  logic signed [CW-1:0] iWrDtRam,
  input  logic [AW-1:0]        iNumOfCoeff,
  input  logic signed [DW-1:0] iFirIn,
  output logic signed [CW-1:0] oRdDtRam,
  output logic signed [OW-1:0] oFirOut,
  output logic                 oFirValid,
  output logic                 oSwapPend
);

  typedef enum logic [1:0] {ST_RUN, ST_LOAD, ST_PEND} state_t;

  state_t state, state_next;

  logic signed [CW-1:0]   shadow [1:TAPS];
  logic signed [CW-1:0]   active [1:TAPS];
  logic signed [ACCW-1:0] prod   [1:TAPS];
  // z[k] holds the partial sum feeding tap k; there is no z[TAPS] because the
  // last tap in the chain always starts from zero.
  logic signed [ACCW-1:0] z      [1:TAPS-1];
  logic signed [ACCW-1:0] z_next [1:TAPS-1];
  logic [AW-1:0]          n;
  logic [AW-1:0]          n_clamp;
  logic signed [ACCW-1:0] y;
  logic [OW-1:0]          y_sat;
  logic signed [CW-1:0]   rd_data;
  logic                   addr_ok, wr_en, rd_en, swap;

  // Full-precision CW+DW product, sign-extended to the accumulator width.
  function automatic logic signed [ACCW-1:0] mul_ext(input logic signed [CW-1:0] c,
                                                     input logic signed [DW-1:0] x);
    logic signed [CW+DW-1:0] p;
    p = $signed({{DW{c[CW-1]}}, c}) * $signed({{CW{x[DW-1]}}, x});
    return {{(ACCW-CW-DW){p[CW+DW-1]}}, p};
  endfunction

  assign addr_ok   = (iAddrRam != '0) && (int'(iAddrRam) <= TAPS);
  assign wr_en     = !iCsnRam && !iWrnRam && iCoeffiUpdateFlag && addr_ok;
  assign rd_en     = !iCsnRam && iWrnRam;
  // A re-rising flag in PEND cancels the swap, so it must also block it here.
  assign swap      = (state == ST_PEND) && iEnSample_300k && !iCoeffiUpdateFlag;
  assign n_clamp   = (int'(iNumOfCoeff) > TAPS) ? AW'(TAPS) : iNumOfCoeff;
  assign oSwapPend = (state == ST_PEND);

  // ---------------- control FSM ----------------
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block evaluation order.
    if (!iRsn) state <= ST_RUN;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      ST_RUN:  if (iCoeffiUpdateFlag) state_next = ST_LOAD;
      ST_LOAD: if (!iCoeffiUpdateFlag) state_next = ST_PEND;
      ST_PEND: begin
        if (iCoeffiUpdateFlag)   state_next = ST_LOAD;
        else if (iEnSample_300k) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  // ---------------- shadow bank and readback ----------------
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    // NOTE: the coefficient banks are flop arrays that must read as zero after
    // reset, so they are reset explicitly rather than inferred as RAM.
    if (!iRsn) begin
      for (int k = 1; k <= TAPS; k++) shadow[k] <= '0;
    end else begin
      for (int k = 1; k <= TAPS; k++)
        if (wr_en && iAddrRam == AW'(k)) shadow[k] <= iWrDtRam;
    end
  end

  // Address 0 and addresses above TAPS match no entry and read back as zero.
  always_comb begin
    rd_data = '0;
    for (int k = 1; k <= TAPS; k++)
      if (iAddrRam == AW'(k)) rd_data = shadow[k];
  end

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn)      oRdDtRam <= '0;
    else if (rd_en) oRdDtRam <= rd_data;
  end

  // ---------------- transposed datapath ----------------
  // Taps above n are masked, so stale coefficients beyond the tap count in the
  // active bank never reach the chain.
  always_comb begin
    for (int k = 1; k <= TAPS; k++) prod[k] = mul_ext(active[k], iFirIn);
    y = (n != '0) ? prod[1] + z[1] : '0;
    for (int k = 1; k <= TAPS - 2; k++)
      z_next[k] = (k + 1 <= int'(n)) ? prod[k+1] + ((k + 1 < int'(n)) ? z[k+1] : '0) : '0;
    z_next[TAPS-1] = (TAPS <= int'(n)) ? prod[TAPS] : '0;
  end

  // Saturate when the bits above the output sign bit are not a pure sign extension.
  always_comb begin
    y_sat = y[OW-1:0];
    if (!((y[ACCW-1:OW-1] == '0) || (y[ACCW-1:OW-1] == '1)))
      y_sat = y[ACCW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
  end

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      for (int k = 1; k <= TAPS; k++) active[k] <= '0;
      for (int k = 1; k <= TAPS - 1; k++) z[k] <= '0;
      n         <= '0;
      oFirOut   <= '0;
      oFirValid <= 1'b0;
    end else begin
      oFirValid <= 1'b0;
      if (swap) begin
        // The swap strobe produces no output; oFirOut holds its last value.
        for (int k = 1; k <= TAPS; k++) active[k] <= shadow[k];
        for (int k = 1; k <= TAPS - 1; k++) z[k] <= '0;
        n <= n_clamp;
      end else if (iEnSample_300k) begin
        for (int k = 1; k <= TAPS - 1; k++) z[k] <= z_next[k];
        oFirOut   <= y_sat;
        oFirValid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_transposed_param.sv
// Self-checking bench for fir_transposed_param: directed vectors with literal
// expectations plus a direct-form reference model compared on every cycle.
module tb_fir_transposed_param;

  localparam int TAPS = 33;
  localparam int CW   = 16;
  localparam int DW   = 3;
  localparam int OW   = 16;
  localparam int ACCW = 24;
  localparam int AW   = 6;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          flag;
  logic          cs;
  logic          wrn;
  logic [AW-1:0] addr;
  logic [CW-1:0] wdata;
  logic [AW-1:0] num;
  logic [DW-1:0] fir_in;
  logic [CW-1:0] rd_data;
  logic [OW-1:0] fir_out;
  logic          fir_valid;
  logic          swap_pend;

  int n_tests = 0;
  int n_fail  = 0;

  fir_transposed_param #(
    .TAPS(TAPS), .CW(CW), .DW(DW), .OW(OW), .ACCW(ACCW), .AW(AW)
  ) dut (
    .iClk_12M          (clk),
    .iRsn              (rst_n),
    .iEnSample_300k    (en),
    .iCoeffiUpdateFlag (flag),
    .iCsnRam           (cs),
    .iWrnRam           (wrn),
    .iAddrRam          (addr),
    .iWrDtRam          (wdata),
    .iNumOfCoeff       (num),
    .iFirIn            (fir_in),
    .oRdDtRam          (rd_data),
    .oFirOut           (fir_out),
    .oFirValid         (fir_valid),
    .oSwapPend         (swap_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Direct form: y = sum_{k=1..N} c_k * x[t-k+1], where samples taken before
  // the last swap or reset count as zero. Result wraps to ACCW then saturates.
  int          m_shadow [1:TAPS];
  int          m_active [1:TAPS];
  int          m_hist   [1:TAPS];
  int          m_n;
  bit          m_load, m_pend;
  bit [OW-1:0] exp_out;
  bit          exp_valid;
  bit [CW-1:0] exp_rd;
  int          m_a;
  bit          m_aok;
  longint      m_acc;

  function automatic bit [OW-1:0] sat_out(input longint s);
    longint m, w;
    m = longint'(1) << ACCW;
    w = s % m;
    if (w >= m / 2) w -= m;
    if (w < -(m / 2)) w += m;
    if (w > (longint'(1) << (OW - 1)) - 1) return {1'b0, {(OW-1){1'b1}}};
    if (w < -(longint'(1) << (OW - 1)))    return {1'b1, {(OW-1){1'b0}}};
    return w[OW-1:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= TAPS; k++) begin
        m_shadow[k] = 0; m_active[k] = 0; m_hist[k] = 0;
      end
      m_n = 0; m_load = 0; m_pend = 0;
      exp_out = '0; exp_valid = 0; exp_rd = '0;
    end else begin
      m_a   = int'(addr);
      m_aok = (m_a >= 1) && (m_a <= TAPS);
      exp_valid = 0;
      if (!cs && wrn) exp_rd = m_aok ? m_shadow[m_a][CW-1:0] : '0;
      if (m_pend && en && !flag) begin
        m_active = m_shadow;
        m_n = (int'(num) > TAPS) ? TAPS : int'(num);
        for (int k = 1; k <= TAPS; k++) m_hist[k] = 0;
      end else if (en) begin
        for (int k = TAPS; k >= 2; k--) m_hist[k] = m_hist[k-1];
        m_hist[1] = int'($signed(fir_in));
        m_acc = 0;
        for (int k = 1; k <= m_n; k++) m_acc += longint'(m_active[k]) * m_hist[k];
        exp_out   = sat_out(m_acc);
        exp_valid = 1;
      end
      if (m_pend) begin
        if (flag) begin m_pend = 0; m_load = 1; end
        else if (en) m_pend = 0;
      end else if (m_load) begin
        if (!flag) begin m_load = 0; m_pend = 1; end
      end else if (flag) begin
        m_load = 1;
      end
      if (!cs && !wrn && flag && m_aok) m_shadow[m_a] = int'($signed(wdata));
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc_out",   fir_out,   exp_out);
      check("cyc_valid", fir_valid, exp_valid);
      check("cyc_pend",  swap_pend, m_pend);
      check("cyc_rd",    rd_data,   exp_rd);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus tasks (each starts and ends on a negedge) ----------------
  task automatic wr(input int a, input int d);
    cs = 1'b0; wrn = 1'b0; addr = a[AW-1:0]; wdata = d[CW-1:0];
    @(negedge clk);
    cs = 1'b1; wrn = 1'b1;
  endtask

  task automatic rd(input int a, input logic [CW-1:0] exp, input string name);
    cs = 1'b0; wrn = 1'b1; addr = a[AW-1:0];
    @(negedge clk);
    cs = 1'b1;
    check(name, rd_data, exp);
  endtask

  task automatic flag_on();
    flag = 1'b1;
    @(negedge clk);
  endtask

  task automatic flag_off(input int ntaps);
    flag = 1'b0; num = ntaps[AW-1:0];
    @(negedge clk);
    check("pend_set", swap_pend, 1'b1);
  endtask

  task automatic samp(input int x, input logic [OW-1:0] exp, input logic v, input string name);
    en = 1'b1; fir_in = x[DW-1:0];
    @(negedge clk);
    en = 1'b0;
    check(name, fir_out, exp);
    check({name, "_valid"}, fir_valid, v);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; flag = 1'b0; cs = 1'b1; wrn = 1'b1;
    addr = '0; wdata = '0; num = '0; fir_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out",   fir_out,   16'h0000);
    check("rst_valid", fir_valid, 1'b0);
    check("rst_rd",    rd_data,   16'h0000);
    check("rst_pend",  swap_pend, 1'b0);

    // Impulse through {1,2,3}
    flag_on(); wr(1, 1); wr(2, 2); wr(3, 3); flag_off(3);
    samp(0, 16'h0000, 1'b0, "imp_swap");
    check("imp_pend_clr", swap_pend, 1'b0);
    samp(1, 16'd1, 1'b1, "imp0");
    samp(0, 16'd2, 1'b1, "imp1");
    samp(0, 16'd3, 1'b1, "imp2");
    samp(0, 16'd0, 1'b1, "imp3");
    samp(0, 16'd0, 1'b1, "imp4");

    // Saturation with N=1
    flag_on(); wr(1, 16'h7FFF); flag_off(1);
    samp(0, 16'h0000, 1'b0, "sat_swap");
    samp(3,  16'h7FFF, 1'b1, "sat_pos");
    samp(-4, 16'h8000, 1'b1, "sat_neg");
    flag_on(); wr(1, 16'h0010); flag_off(1);
    samp(0, 16'h8000, 1'b0, "sat_swap2");
    samp(-2, 16'hFFE0, 1'b1, "neg_small");

    // Runtime tap count: bank 1..5 but only 2 taps
    flag_on(); for (int i = 1; i <= 5; i++) wr(i, i); flag_off(2);
    samp(0, 16'hFFE0, 1'b0, "n2_swap");
    samp(1, 16'd1, 1'b1, "n2_0");
    samp(0, 16'd2, 1'b1, "n2_1");
    samp(0, 16'd0, 1'b1, "n2_2");
    samp(0, 16'd0, 1'b1, "n2_3");

    // Tap count 40 clamps to 33: the last tap is reached
    flag_on(); wr(33, 7); flag_off(40);
    samp(0, 16'd0, 1'b0, "n40_swap");
    for (int i = 1; i <= 34; i++)
      samp((i == 1) ? 1 : 0, (i <= 5) ? 16'(i) : ((i == 33) ? 16'd7 : 16'd0), 1'b1, "n40_imp");

    // Live reload with continuous x=1
    flag_on(); wr(1, 1); wr(2, 2); wr(3, 3); flag_off(3);
    samp(1, 16'd0, 1'b0, "lr_swap");
    samp(1, 16'd1, 1'b1, "lr_ramp0");
    samp(1, 16'd3, 1'b1, "lr_ramp1");
    samp(1, 16'd6, 1'b1, "lr_steady");
    flag_on();
    samp(1, 16'd6, 1'b1, "lr_in_load");
    wr(1, 4); wr(2, 0); wr(3, 0);
    samp(1, 16'd6, 1'b1, "lr_in_load2");
    flag_off(3);
    samp(1, 16'd6, 1'b0, "lr_swap2");
    samp(1, 16'd4, 1'b1, "lr_new0");
    samp(1, 16'd4, 1'b1, "lr_new1");

    // Cancel: flag re-rises during PEND
    flag_on(); wr(1, 9); flag_off(3);
    flag_on();
    check("cancel_pend", swap_pend, 1'b0);
    samp(1, 16'd4, 1'b1, "cancel_old");

    // Flag fall coincident with a strobe: normal sample, swap deferred
    flag = 1'b0; num = 6'd3;
    samp(1, 16'd4, 1'b1, "fall_strobe");
    check("fall_pend", swap_pend, 1'b1);
    samp(1, 16'd4, 1'b0, "fall_swap");
    samp(1, 16'd9, 1'b1, "fall_new0");
    samp(1, 16'd9, 1'b1, "fall_new1");

    // Bank {2,3} leaves a nonzero partial sum in the chain
    flag_on(); wr(1, 2); wr(2, 3); flag_off(3);
    samp(1, 16'd9, 1'b0, "z_swap");
    samp(1, 16'd2, 1'b1, "z_0");
    samp(1, 16'd5, 1'b1, "z_1");

    // Readback and ignored writes
    flag_on();
    wr(5, 16'h1234);
    rd(5, 16'h1234, "rb_5");
    wr(0, 16'h5555);
    wr(34, 16'h5555);
    rd(0, 16'h0000, "rb_addr0");
    rd(34, 16'h0000, "rb_addr34");
    rd(5, 16'h1234, "rb_5_again");
    flag_off(3);
    wr(5, 16'h0BAD);
    rd(5, 16'h1234, "rb_flag_low");

    // Reset while PEND with nonzero chain
    rst_n = 1'b0;
    #1;
    check("mid_rst_out",   fir_out,   16'h0000);
    check("mid_rst_valid", fir_valid, 1'b0);
    check("mid_rst_rd",    rd_data,   16'h0000);
    check("mid_rst_pend",  swap_pend, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    samp(1, 16'd0, 1'b1, "post_rst0");
    samp(0, 16'd0, 1'b1, "post_rst1");
    samp(0, 16'd0, 1'b1, "post_rst2");
    rd(1, 16'h0000, "post_rst_bank");
    check("post_rst_pend", swap_pend, 1'b0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
